// File: rtl/cpu_io_pkg.sv
`default_nettype none
// ============================================================================
//  cpu_io_pkg
//  Shared types and framing constants for the CPU output-to-UART bridge.
//  Revision: 1.0
// ============================================================================
package cpu_io_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  function automatic int bytes_per_word(input int width);
    return width / UART_DATA_BITS;
  endfunction

  // Counter/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  uart_tx_byte
//  Serialises one byte as an 8N1 frame and pulses o_done in the last cycle.
//  Revision: 1.0
// ============================================================================
module uart_tx_byte
  import cpu_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_byte,
  input  logic       i_valid,
  output logic       o_tx,
  output logic       o_done
);

  localparam int               CNT_W       = clog2_min1(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] C_RELOAD    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       C_LAST_DATA = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]       C_LAST_STOP = 3'(UART_STOP_BITS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [2:0]       w_bit_next;
  logic [7:0]       r_data;
  logic             r_tx;
  logic             w_tx_next;
  logic             w_tick;
  logic             w_reload;
  logic             w_done;

  // A zero count ends the current bit; the counter only decrements while non-zero.
  assign w_tick = (r_cnt == '0);

  always_comb begin
    w_next     = r_state;
    w_bit_next = r_bit;
    w_reload   = 1'b0;
    w_done     = 1'b0;
    w_tx_next  = 1'b1;
    case (r_state)
      IDLE: begin
        if (i_valid) begin
          w_next   = START;
          w_reload = 1'b1;
        end
      end
      START: begin
        if (w_tick) begin
          w_next     = DATA;
          w_bit_next = '0;
          w_reload   = 1'b1;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_reload = 1'b1;
          if (r_bit == C_LAST_DATA) begin
            w_next     = STOP;
            w_bit_next = '0;
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          w_reload = 1'b1;
          if (r_bit == C_LAST_STOP) begin
            w_next = IDLE;
            w_done = 1'b1;
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
    case (w_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = r_data[w_bit_next];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_data  <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_next;
      r_bit   <= w_bit_next;
      r_tx    <= w_tx_next;
      if (w_reload) begin
        r_cnt <= C_RELOAD;
      end else if (!w_tick) begin
        r_cnt <= r_cnt - C_CNT_ONE;
      end
      if (r_state == IDLE && i_valid) begin
        r_data <= i_byte;
      end
    end
  end

  assign o_tx   = r_tx;
  assign o_done = w_done;

endmodule
`default_nettype wire

// File: rtl/cpu_out_uart_bridge.sv
`default_nettype none
// ============================================================================
//  cpu_out_uart_bridge
//  Buffers CPU output words in a FIFO and streams them MSB-byte-first as UART 8N1.
//  Revision: 1.0
// ============================================================================
module cpu_out_uart_bridge
  import cpu_io_pkg::*;
#(
  parameter int WIDTH        = 24,
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   outFlag,
  input  logic [WIDTH-1:0]       out,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int              AW         = $clog2(DEPTH);
  localparam int              BPW        = bytes_per_word(WIDTH);
  localparam int              IW         = clog2_min1(BPW);
  localparam logic [AW:0]     C_DEPTH    = (AW + 1)'(DEPTH);
  localparam logic [AW:0]     C_CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0]   C_PTR_ONE  = AW'(1);
  localparam logic [IW-1:0]   C_LAST_IDX = IW'(BPW - 1);
  localparam logic [IW-1:0]   C_IDX_ONE  = IW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic [WIDTH-1:0] r_word;
  logic [IW-1:0]    r_idx;
  state_t           r_state;
  state_t           w_next;
  logic             w_pop;
  logic             w_push;
  logic             w_full;
  logic             w_load;
  logic             w_idx_inc;
  logic             w_done;
  logic [7:0]       w_byte;

  assign w_full = (r_count == C_DEPTH);
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign w_push = outFlag && (!w_full || w_pop);
  assign w_byte = r_word[(WIDTH - 1) - 8 * int'(r_idx) -: 8];

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + C_CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - C_CNT_ONE;
      end
      if (outFlag && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= out;
    end
  end

  // START here covers the whole byte frame; uart_tx_byte tracks START/DATA/STOP.
  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_load    = 1'b0;
    w_idx_inc = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_pop  = 1'b1;
          w_next = LOAD;
        end
      end
      LOAD: begin
        w_load = 1'b1;
        w_next = START;
      end
      START: begin
        if (w_done) begin
          if (r_idx == C_LAST_IDX) begin
            w_next = IDLE;
          end else begin
            w_idx_inc = 1'b1;
            w_next    = LOAD;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_next;
      if (w_pop) begin
        r_word <= r_mem[r_rd_ptr];
        r_idx  <= '0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + C_IDX_ONE;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .clk     (clock),
    .rst_n   (reset),
    .i_byte  (w_byte),
    .i_valid (w_load),
    .o_tx    (tx),
    .o_done  (w_done)
  );

  assign busy     = (r_count != '0) || (r_state != IDLE);
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cpu_out_uart_bridge.sv
`default_nettype none
// ============================================================================
//  tb_cpu_out_uart_bridge
//  Directed self-checking bench: CLKS_PER_BIT=4, DEPTH=4, WIDTH=24.
//  Revision: 1.0
// ============================================================================
module tb_cpu_out_uart_bridge;

  logic        clock;
  logic        reset;
  logic        outFlag;
  logic [23:0] out;
  logic        tx;
  logic        busy;
  logic [2:0]  count;
  logic        overflow;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  rxq[$];

  cpu_out_uart_bridge #(
    .WIDTH        (24),
    .DEPTH        (4),
    .CLKS_PER_BIT (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .outFlag  (outFlag),
    .out      (out),
    .tx       (tx),
    .busy     (busy),
    .count    (count),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // UART receiver sampling on falling edges, roughly mid-bit.
  initial begin : uart_monitor
    logic [7:0] rx_byte;
    rx_byte = '0;
    forever begin
      @(negedge clock);
      if (tx === 1'b0) begin
        repeat (5) @(negedge clock);
        for (int k = 0; k < 8; k++) begin
          rx_byte[k] = tx;
          if (k < 7) repeat (4) @(negedge clock);
        end
        repeat (4) @(negedge clock);
        rxq.push_back(rx_byte);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; outFlag = 1'b0; out = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({tx, busy, count, overflow} !== 6'b1_0_000_0) begin
        errors++;
        $display("FAIL reset_hold: got tx=%b busy=%b count=%0d ovf=%b, expected 1 0 0 0", tx, busy, count, overflow);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({tx, busy, count, overflow} !== 6'b1_0_000_0) begin
        errors++;
        $display("FAIL reset_idle: cycle %0d got tx=%b busy=%b count=%0d ovf=%b, expected 1 0 0 0", i, tx, busy, count, overflow);
      end
    end
  endtask

  task automatic test_single();
    int         n;
    logic [7:0] exp[$];
    exp = '{8'h00, 8'h00, 8'h07};
    rxq.delete();
    outFlag = 1'b1; out = 24'h000007;
    tick();
    outFlag = 1'b0;
    checks++;
    if (count !== 3'd1) begin
      errors++; $display("FAIL single_push_count: got %0d, expected 1", count);
    end
    tick();
    checks++;
    if ({count, busy, tx} !== 5'b000_1_1) begin
      errors++; $display("FAIL single_pop: got count=%0d busy=%b tx=%b, expected 0 1 1", count, busy, tx);
    end
    tick();
    checks++;
    if (tx !== 1'b0) begin
      errors++; $display("FAIL single_start_bit: got tx=%b, expected 0", tx);
    end
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      tick(); n++;
    end
    checks++;
    if (n != 122) begin
      errors++; $display("FAIL single_busy_len: got %0d cycles, expected 122", n);
    end
    checks++;
    if (rxq.size() != exp.size()) begin
      errors++; $display("FAIL single_bytes_len: got %0d bytes, expected %0d", rxq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      if (i < rxq.size()) begin
        checks++;
        if (rxq[i] !== exp[i]) begin
          errors++; $display("FAIL single_byte[%0d]: got %02h, expected %02h", i, rxq[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int         n;
    logic [2:0] exp_cnt[5];
    logic [7:0] exp[$];
    exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    exp = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h03,
            8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h05};
    rxq.delete();
    for (int i = 0; i < 5; i++) begin
      outFlag = 1'b1; out = 24'(i + 1);
      tick();
      checks++;
      if (count !== exp_cnt[i]) begin
        errors++; $display("FAIL b2b_count[%0d]: got %0d, expected %0d", i, count, exp_cnt[i]);
      end
    end
    outFlag = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL b2b_overflow: got %b, expected 0", overflow);
    end
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      tick(); n++;
    end
    checks++;
    if (n != 616) begin
      errors++; $display("FAIL b2b_busy_len: got %0d cycles, expected 616", n);
    end
    checks++;
    if (rxq.size() != exp.size()) begin
      errors++; $display("FAIL b2b_bytes_len: got %0d bytes, expected %0d", rxq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      if (i < rxq.size()) begin
        checks++;
        if (rxq[i] !== exp[i]) begin
          errors++; $display("FAIL b2b_byte[%0d]: got %02h, expected %02h", i, rxq[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_full_push_pop();
    int          n;
    logic [23:0] words[6];
    logic [7:0]  exp[$];
    words = '{24'h0A0B0C, 24'h112233, 24'h445566, 24'h778899, 24'hAABBCC, 24'hDDEEFF};
    exp = '{8'h0A, 8'h0B, 8'h0C, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
            8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    rxq.delete();
    outFlag = 1'b1; out = words[0];
    tick();
    outFlag = 1'b0;
    tick();
    for (int i = 1; i < 5; i++) begin
      outFlag = 1'b1; out = words[i];
      tick();
    end
    outFlag = 1'b0;
    checks++;
    if (count !== 3'd4) begin
      errors++; $display("FAIL fpp_filled: got count=%0d, expected 4", count);
    end
    repeat (119) tick();
    checks++;
    if (count !== 3'd4) begin
      errors++; $display("FAIL fpp_before_pop: got count=%0d, expected 4", count);
    end
    outFlag = 1'b1; out = words[5];
    tick();
    outFlag = 1'b0;
    checks++;
    if ({count, overflow} !== 4'b100_0) begin
      errors++; $display("FAIL fpp_same_edge: got count=%0d ovf=%b, expected 4 0", count, overflow);
    end
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      tick(); n++;
    end
    checks++;
    if (n != 619) begin
      errors++; $display("FAIL fpp_busy_len: got %0d cycles, expected 619", n);
    end
    checks++;
    if (rxq.size() != exp.size()) begin
      errors++; $display("FAIL fpp_bytes_len: got %0d bytes, expected %0d", rxq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      if (i < rxq.size()) begin
        checks++;
        if (rxq[i] !== exp[i]) begin
          errors++; $display("FAIL fpp_byte[%0d]: got %02h, expected %02h", i, rxq[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int          n;
    logic [23:0] words[5];
    logic [7:0]  exp[$];
    words = '{24'h010203, 24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0};
    exp = '{8'h01, 8'h02, 8'h03, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60,
            8'h70, 8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0};
    rxq.delete();
    outFlag = 1'b1; out = words[0];
    tick();
    outFlag = 1'b0;
    tick();
    for (int i = 1; i < 5; i++) begin
      outFlag = 1'b1; out = words[i];
      tick();
    end
    checks++;
    if ({count, overflow} !== 4'b100_0) begin
      errors++; $display("FAIL ovf_full: got count=%0d ovf=%b, expected 4 0", count, overflow);
    end
    outFlag = 1'b1; out = 24'hABCDEF;
    tick();
    outFlag = 1'b0;
    checks++;
    if ({count, overflow} !== 4'b100_1) begin
      errors++; $display("FAIL ovf_drop: got count=%0d ovf=%b, expected 4 1", count, overflow);
    end
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      tick(); n++;
    end
    checks++;
    if (n != 614) begin
      errors++; $display("FAIL ovf_busy_len: got %0d cycles, expected 614", n);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %b, expected 1", overflow);
    end
    checks++;
    if (rxq.size() != exp.size()) begin
      errors++; $display("FAIL ovf_bytes_len: got %0d bytes, expected %0d", rxq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      if (i < rxq.size()) begin
        checks++;
        if (rxq[i] !== exp[i]) begin
          errors++; $display("FAIL ovf_byte[%0d]: got %02h, expected %02h", i, rxq[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int         n;
    logic [7:0] exp[$];
    exp = '{8'h12, 8'h34, 8'h56};
    outFlag = 1'b1; out = 24'h5A3CC3;
    tick();
    outFlag = 1'b0;
    repeat (51) tick();
    // Second byte 0x3C, bit 1 (a zero) is on the line now.
    checks++;
    if (tx !== 1'b0) begin
      errors++; $display("FAIL mid_before_reset: got tx=%b, expected 0", tx);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({tx, busy, count, overflow} !== 6'b1_0_000_0) begin
      errors++; $display("FAIL mid_reset: got tx=%b busy=%b count=%0d ovf=%b, expected 1 0 0 0", tx, busy, count, overflow);
    end
    reset = 1'b1;
    repeat (60) tick();
    checks++;
    if ({tx, busy} !== 2'b1_0) begin
      errors++; $display("FAIL mid_quiet: got tx=%b busy=%b, expected 1 0", tx, busy);
    end
    rxq.delete();
    outFlag = 1'b1; out = 24'h123456;
    tick();
    outFlag = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      tick(); n++;
    end
    checks++;
    if (n != 124) begin
      errors++; $display("FAIL mid_busy_len: got %0d cycles, expected 124", n);
    end
    checks++;
    if (rxq.size() != exp.size()) begin
      errors++; $display("FAIL mid_bytes_len: got %0d bytes, expected %0d", rxq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      if (i < rxq.size()) begin
        checks++;
        if (rxq[i] !== exp[i]) begin
          errors++; $display("FAIL mid_byte[%0d]: got %02h, expected %02h", i, rxq[i], exp[i]);
        end
      end
    end
  endtask

  initial begin : main
    reset   = 1'b0;
    outFlag = 1'b0;
    out     = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_push_pop();
    test_overflow();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
